// File: rtl/battle_turn_ctrl.sv
// Turn-based battle sequencer: menu, fight timing bar, damage, enemy attack
// window and win/lose/spare outcome, driven by frame_tick and USB keycodes.
module battle_turn_ctrl #(
    parameter int PLAYER_HP_MAX = 20,
    parameter int ENEMY_HP_MAX  = 30,
    parameter int BAR_LEN       = 160,
    parameter int ENEMY_FRAMES  = 300,
    parameter int ENEMY_DMG     = 4,
    parameter int INVULN_FRAMES = 30,
    parameter int ITEM_HEAL     = 10,
    parameter int ITEMS_INIT    = 3,
    parameter int SHOW_FRAMES   = 60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       start_battle,
    input  logic [7:0] keycode,
    input  logic       hit,
    output logic [2:0] phase,
    output logic [1:0] menu_sel,
    output logic [7:0] bar_pos,
    output logic [3:0] last_dmg,
    output logic [7:0] player_hp,
    output logic [7:0] enemy_hp,
    output logic [1:0] items_left,
    output logic       soul_active,
    output logic       battle_done,
    output logic [1:0] result
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MENU   = 3'd1;
    localparam logic [2:0] S_FIGHT  = 3'd2;
    localparam logic [2:0] S_SHOW   = 3'd3;
    localparam logic [2:0] S_DIALOG = 3'd4;
    localparam logic [2:0] S_ENEMY  = 3'd5;
    localparam logic [2:0] S_END    = 3'd6;

    localparam logic [1:0] M_FIGHT = 2'd0;
    localparam logic [1:0] M_ACT   = 2'd1;
    localparam logic [1:0] M_ITEM  = 2'd2;

    localparam logic [1:0] R_NONE   = 2'd0;
    localparam logic [1:0] R_WIN    = 2'd1;
    localparam logic [1:0] R_LOSE   = 2'd2;
    localparam logic [1:0] R_SPARED = 2'd3;

    localparam logic [7:0] KEY_Z     = 8'h1D;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;

    localparam int CW = $clog2((ENEMY_FRAMES > SHOW_FRAMES) ? ENEMY_FRAMES : SHOW_FRAMES);
    localparam int IW = $clog2(INVULN_FRAMES + 1);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_FRAMES - 1);
    localparam logic [CW-1:0] ENEMY_LAST = CW'(ENEMY_FRAMES - 1);
    localparam logic [7:0]    BAR_MID    = 8'(BAR_LEN / 2);
    localparam logic [7:0]    BAR_LAST   = 8'(BAR_LEN - 1);
    localparam logic [7:0]    HP_MAX     = 8'(PLAYER_HP_MAX);
    localparam logic [7:0]    EDMG       = 8'(ENEMY_DMG);

    logic [7:0]    prev_key;
    logic [CW-1:0] frame_cnt;
    logic [IW-1:0] invuln;

    logic       press_z, press_left, press_right;
    logic [7:0] bar_dist;
    logic [3:0] hit_dmg;
    logic [7:0] enemy_after;
    logic [8:0] healed;
    logic [7:0] heal_hp;
    logic       spare_ok;
    logic       hit_taken;
    logic [7:0] hp_after_hit;

    always_comb begin
        press_z     = (keycode == KEY_Z)     && (prev_key != KEY_Z);
        press_left  = (keycode == KEY_LEFT)  && (prev_key != KEY_LEFT);
        press_right = (keycode == KEY_RIGHT) && (prev_key != KEY_RIGHT);
    end

    // Damage from distance to bar centre, using the pre-increment bar_pos.
    always_comb begin
        bar_dist = (bar_pos >= BAR_MID) ? (bar_pos - BAR_MID) : (BAR_MID - bar_pos);
        if (bar_dist < 8'd8)
            hit_dmg = 4'd10;
        else if (bar_dist < 8'd24)
            hit_dmg = 4'd5;
        else
            hit_dmg = 4'd2;
        enemy_after = (enemy_hp > {4'b0000, hit_dmg}) ? (enemy_hp - {4'b0000, hit_dmg}) : '0;
    end

    always_comb begin
        healed   = {1'b0, player_hp} + 9'(ITEM_HEAL);
        heal_hp  = (healed > {1'b0, HP_MAX}) ? HP_MAX : healed[7:0];
        spare_ok = ({enemy_hp, 2'b00} <= 10'(ENEMY_HP_MAX));
    end

    always_comb begin
        hit_taken    = hit && (invuln == '0);
        hp_after_hit = player_hp;
        if (hit_taken)
            hp_after_hit = (player_hp > EDMG) ? (player_hp - EDMG) : '0;
    end

    always_comb soul_active = (phase == S_ENEMY);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            phase       <= S_IDLE;
            menu_sel    <= '0;
            bar_pos     <= '0;
            last_dmg    <= '0;
            player_hp   <= HP_MAX;
            enemy_hp    <= 8'(ENEMY_HP_MAX);
            items_left  <= 2'(ITEMS_INIT);
            result      <= R_NONE;
            battle_done <= 1'b0;
            prev_key    <= '0;
            frame_cnt   <= '0;
            invuln      <= '0;
        end else begin
            prev_key    <= keycode;
            battle_done <= 1'b0;
            case (phase)
                S_IDLE: begin
                    if (start_battle) begin
                        player_hp  <= HP_MAX;
                        enemy_hp   <= 8'(ENEMY_HP_MAX);
                        items_left <= 2'(ITEMS_INIT);
                        menu_sel   <= '0;
                        result     <= R_NONE;
                        phase      <= S_MENU;
                    end
                end
                S_MENU: begin
                    if (press_left)
                        menu_sel <= menu_sel - 2'd1;
                    else if (press_right)
                        menu_sel <= menu_sel + 2'd1;
                    else if (press_z) begin
                        case (menu_sel)
                            M_FIGHT: begin
                                bar_pos <= '0;
                                phase   <= S_FIGHT;
                            end
                            M_ACT: phase <= S_DIALOG;
                            M_ITEM: begin
                                if (items_left != '0) begin
                                    player_hp  <= heal_hp;
                                    items_left <= items_left - 2'd1;
                                    phase      <= S_DIALOG;
                                end
                            end
                            default: begin
                                if (spare_ok) begin
                                    result <= R_SPARED;
                                    phase  <= S_END;
                                end else begin
                                    phase <= S_DIALOG;
                                end
                            end
                        endcase
                    end
                end
                S_FIGHT: begin
                    if (press_z) begin
                        enemy_hp  <= enemy_after;
                        last_dmg  <= hit_dmg;
                        frame_cnt <= '0;
                        phase     <= S_SHOW;
                    end else if (frame_tick) begin
                        if (bar_pos == BAR_LAST) begin
                            last_dmg  <= '0;
                            frame_cnt <= '0;
                            phase     <= S_SHOW;
                        end else begin
                            bar_pos <= bar_pos + 8'd1;
                        end
                    end
                end
                S_SHOW: begin
                    if (frame_tick) begin
                        if (frame_cnt == SHOW_LAST) begin
                            if (enemy_hp == '0) begin
                                result <= R_WIN;
                                phase  <= S_END;
                            end else begin
                                frame_cnt <= '0;
                                invuln    <= '0;
                                phase     <= S_ENEMY;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + CW'(1);
                        end
                    end
                end
                S_DIALOG: begin
                    if (press_z) begin
                        frame_cnt <= '0;
                        invuln    <= '0;
                        phase     <= S_ENEMY;
                    end
                end
                S_ENEMY: begin
                    // Hit lands first, then the LOSE check, then window expiry.
                    if (frame_tick) begin
                        player_hp <= hp_after_hit;
                        if (hit_taken)
                            invuln <= IW'(INVULN_FRAMES);
                        else if (invuln != '0)
                            invuln <= invuln - IW'(1);
                        if (hp_after_hit == '0) begin
                            result <= R_LOSE;
                            phase  <= S_END;
                        end else if (frame_cnt == ENEMY_LAST) begin
                            phase <= S_MENU;
                        end else begin
                            frame_cnt <= frame_cnt + CW'(1);
                        end
                    end
                end
                S_END: begin
                    if (press_z) begin
                        battle_done <= 1'b1;
                        phase       <= S_IDLE;
                    end
                end
                default: phase <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Scoreboard bench for battle_turn_ctrl: a spec-level model pushes every output
// change with its cycle stamp; a monitor pops and compares each DUT output change.
module tb_battle_turn_ctrl;

    localparam int PHP = 20, EHP = 30, BAR = 160, EFR = 300, EDMG = 4;
    localparam int INV = 30, HEAL = 10, ITEMS = 3, SHOWF = 60;
    localparam logic [7:0] KZ = 8'h1D, KX = 8'h1B, KL = 8'h50, KR = 8'h4F;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start_battle = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       hit = 1'b0;
    logic [2:0] phase;
    logic [1:0] menu_sel;
    logic [7:0] bar_pos;
    logic [3:0] last_dmg;
    logic [7:0] player_hp;
    logic [7:0] enemy_hp;
    logic [1:0] items_left;
    logic       soul_active;
    logic       battle_done;
    logic [1:0] result;

    battle_turn_ctrl #(
        .PLAYER_HP_MAX(PHP), .ENEMY_HP_MAX(EHP), .BAR_LEN(BAR),
        .ENEMY_FRAMES(EFR), .ENEMY_DMG(EDMG), .INVULN_FRAMES(INV),
        .ITEM_HEAL(HEAL), .ITEMS_INIT(ITEMS), .SHOW_FRAMES(SHOWF)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start_battle(start_battle),
        .keycode(keycode), .hit(hit), .phase(phase), .menu_sel(menu_sel),
        .bar_pos(bar_pos), .last_dmg(last_dmg), .player_hp(player_hp),
        .enemy_hp(enemy_hp), .items_left(items_left), .soul_active(soul_active),
        .battle_done(battle_done), .result(result)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [2:0] ph;
        logic [1:0] sel;
        logic [7:0] bar;
        logic [3:0] dmg;
        logic [7:0] php;
        logic [7:0] ehp;
        logic [1:0] items;
        logic       soul;
        logic       done;
        logic [1:0] res;
    } snap_t;

    typedef struct {
        int    cyc;
        snap_t s;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    bit   armed = 1'b0;

    // Reference model state: phases by name, counters count ticks seen so far.
    int m_ph, m_sel, m_bar, m_dmg, m_php, m_ehp, m_items, m_res, m_done, m_pk;
    int m_show, m_win, m_lasthit;
    snap_t m_prev;

    function automatic snap_t dut_snap();
        snap_t s;
        s.ph = phase; s.sel = menu_sel; s.bar = bar_pos; s.dmg = last_dmg;
        s.php = player_hp; s.ehp = enemy_hp; s.items = items_left;
        s.soul = soul_active; s.done = battle_done; s.res = result;
        return s;
    endfunction

    function automatic snap_t reset_snap();
        snap_t s;
        s.ph = 3'd0; s.sel = 2'd0; s.bar = 8'd0; s.dmg = 4'd0;
        s.php = 8'(PHP); s.ehp = 8'(EHP); s.items = 2'(ITEMS);
        s.soul = 1'b0; s.done = 1'b0; s.res = 2'd0;
        return s;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.ph = 3'(m_ph); s.sel = 2'(m_sel); s.bar = 8'(m_bar); s.dmg = 4'(m_dmg);
        s.php = 8'(m_php); s.ehp = 8'(m_ehp); s.items = 2'(m_items);
        s.soul = (m_ph == 5); s.done = (m_done != 0); s.res = 2'(m_res);
        return s;
    endfunction

    task automatic enter_enemy();
        m_win = 0;
        m_lasthit = -1000;
        m_ph = 5;
    endtask

    task automatic resolve(input int dmg);
        m_ehp = (m_ehp > dmg) ? m_ehp - dmg : 0;
        m_dmg = dmg;
        m_show = 0;
        m_ph = 3;
    endtask

    task automatic model_step();
        bit zp, lp, rp;
        int d;
        snap_t cur;
        exp_t e;
        cycle++;
        if (Reset) begin
            m_ph = 0; m_sel = 0; m_bar = 0; m_dmg = 0; m_php = PHP; m_ehp = EHP;
            m_items = ITEMS; m_res = 0; m_done = 0; m_pk = 0;
        end else begin
            zp = (keycode == KZ) && (m_pk != int'(KZ));
            lp = (keycode == KL) && (m_pk != int'(KL));
            rp = (keycode == KR) && (m_pk != int'(KR));
            m_pk = int'(keycode);
            m_done = 0;
            case (m_ph)
                0: if (start_battle) begin
                    m_php = PHP; m_ehp = EHP; m_items = ITEMS; m_sel = 0; m_res = 0; m_ph = 1;
                end
                1: begin
                    if (lp) m_sel = (m_sel + 3) % 4;
                    else if (rp) m_sel = (m_sel + 1) % 4;
                    else if (zp) begin
                        if (m_sel == 0) begin m_bar = 0; m_ph = 2; end
                        else if (m_sel == 1) m_ph = 4;
                        else if (m_sel == 2) begin
                            if (m_items > 0) begin
                                m_php = (m_php + HEAL > PHP) ? PHP : m_php + HEAL;
                                m_items--;
                                m_ph = 4;
                            end
                        end else begin
                            if (m_ehp * 4 <= EHP) begin m_res = 3; m_ph = 6; end
                            else m_ph = 4;
                        end
                    end
                end
                2: begin
                    if (zp) begin
                        d = (m_bar >= BAR / 2) ? m_bar - BAR / 2 : BAR / 2 - m_bar;
                        resolve((d < 8) ? 10 : (d < 24) ? 5 : 2);
                    end else if (frame_tick) begin
                        if (m_bar + 1 > BAR - 1) resolve(0);
                        else m_bar++;
                    end
                end
                3: if (frame_tick) begin
                    m_show++;
                    if (m_show == SHOWF) begin
                        if (m_ehp == 0) begin m_res = 1; m_ph = 6; end
                        else enter_enemy();
                    end
                end
                4: if (zp) enter_enemy();
                5: if (frame_tick) begin
                    m_win++;
                    if (hit && (m_win - m_lasthit > INV)) begin
                        m_php = (m_php > EDMG) ? m_php - EDMG : 0;
                        m_lasthit = m_win;
                    end
                    if (m_php == 0) begin m_res = 2; m_ph = 6; end
                    else if (m_win == EFR) m_ph = 1;
                end
                6: if (zp) begin m_done = 1; m_ph = 0; end
                default: m_ph = 0;
            endcase
        end
        cur = model_snap();
        if (armed && cur != m_prev) begin
            e.cyc = cycle;
            e.s = cur;
            sb.push_back(e);
        end
        m_prev = cur;
    endtask

    initial begin
        m_prev = reset_snap();
        forever begin
            @(posedge Clk);
            model_step();
        end
    end

    initial begin
        snap_t mprev, cur;
        exp_t  e;
        forever begin
            @(negedge Clk);
            cur = dut_snap();
            if (armed && cur !== mprev) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d got=%h want=no_change", cycle, cur);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cycle || e.s !== cur) begin
                        bad++;
                        $display("FAIL sb_change cyc=%0d got=%h want=%h at cyc=%0d", cycle, cur, e.s, e.cyc);
                    end
                end
            end
            mprev = cur;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic key_tap(input logic [7:0] k);
        keycode = k;
        step();
        keycode = 8'h00;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic start();
        start_battle = 1'b1;
        step();
        start_battle = 1'b0;
        step();
    endtask

    logic [7:0] keys [8];

    initial begin
        keys = '{8'h00, 8'h00, 8'h00, KZ, KX, KL, KR, 8'h04};
        step();
        step();
        check("reset_state", 64'(dut_snap()), 64'(reset_snap()));
        armed = 1'b1;
        Reset = 1'b0;
        step();

        start();
        check("start_menu", 64'(phase), 64'd1);
        key_tap(KZ);
        ticks(80);
        key_tap(KZ);
        check("centre_dmg", 64'(last_dmg), 64'd10);
        check("centre_ehp", 64'(enemy_hp), 64'd20);
        check("centre_show", 64'(phase), 64'd3);
        ticks(SHOWF);
        check("show_to_enemy", 64'(phase), 64'd5);
        check("soul_on", 64'(soul_active), 64'd1);

        hit = 1'b1;
        ticks(40);
        hit = 1'b0;
        check("invuln_two_hits", 64'(player_hp), 64'd12);
        ticks(EFR - 40);
        check("window_expiry", 64'(phase), 64'd1);

        key_tap(KL);
        check("menu_wrap_left", 64'(menu_sel), 64'd3);
        keycode = KR;
        repeat (10) step();
        keycode = 8'h00;
        step();
        check("held_right_once", 64'(menu_sel), 64'd0);

        key_tap(KR);
        key_tap(KR);
        key_tap(KZ);
        check("item_heal_cap", 64'(player_hp), 64'd20);
        check("item_count", 64'(items_left), 64'd2);
        for (int i = 0; i < 2; i++) begin
            key_tap(KZ);
            ticks(EFR);
            key_tap(KZ);
        end
        key_tap(KZ);
        ticks(EFR);
        key_tap(KZ);
        check("no_items_stay", 64'(phase), 64'd1);
        check("no_items_zero", 64'(items_left), 64'd0);

        key_tap(KL);
        key_tap(KL);
        key_tap(KZ);
        ticks(BAR);
        check("bar_miss_dmg", 64'(last_dmg), 64'd0);
        check("bar_miss_ehp", 64'(enemy_hp), 64'd20);
        ticks(SHOWF);
        ticks(EFR);

        key_tap(KZ);
        ticks(72);
        keycode = KZ;
        frame_tick = 1'b1;
        step();
        keycode = 8'h00;
        frame_tick = 1'b0;
        step();
        check("z_tick_d8_dmg", 64'(last_dmg), 64'd5);
        check("z_tick_bar", 64'(bar_pos), 64'd72);
        check("z_tick_ehp", 64'(enemy_hp), 64'd15);
        ticks(SHOWF);
        ticks(EFR);

        key_tap(KZ);
        ticks(80);
        key_tap(KZ);
        ticks(SHOWF);
        ticks(EFR);
        key_tap(KL);
        key_tap(KZ);
        check("spare_result", 64'(result), 64'd3);
        check("spare_end", 64'(phase), 64'd6);
        keycode = KZ;
        step();
        check("done_pulse", 64'(battle_done), 64'd1);
        check("done_idle", 64'(phase), 64'd0);
        keycode = 8'h00;
        step();
        check("done_single", 64'(battle_done), 64'd0);
        check("result_held", 64'(result), 64'd3);

        start();
        key_tap(KR);
        key_tap(KZ);
        key_tap(KZ);
        hit = 1'b1;
        ticks(130);
        hit = 1'b0;
        check("lose_result", 64'(result), 64'd2);
        check("lose_end", 64'(phase), 64'd6);
        check("lose_hp", 64'(player_hp), 64'd0);
        key_tap(KZ);

        start();
        key_tap(KR);
        key_tap(KZ);
        key_tap(KZ);
        ticks(10);
        Reset = 1'b1;
        step();
        check("abort_reset", 64'(dut_snap()), 64'(reset_snap()));
        Reset = 1'b0;
        step();

        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 9) < 3) keycode = keys[$urandom_range(0, 7)];
            frame_tick   = ($urandom_range(0, 1) == 1);
            hit          = ($urandom_range(0, 3) == 0);
            start_battle = ($urandom_range(0, 49) == 0);
            Reset        = ($urandom_range(0, 2999) == 0);
            step();
        end
        keycode = 8'h00;
        frame_tick = 1'b0;
        hit = 1'b0;
        start_battle = 1'b0;
        Reset = 1'b0;
        repeat (5) step();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
